// File: rtl/serial_operand_loader.sv
// Serial operand loader: shifts a 10-bit frame (opcode, A, B; each field LSB first),
// issues the operands to a downstream ALU stage and captures its result.
module serial_operand_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       sin_valid,
  input  logic       sin,
  input  logic [3:0] e_in,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic [1:0] c_out,
  output logic [3:0] result,
  output logic       done,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OP      = 3'd1,
    LOAD_A  = 3'd2,
    LOAD_B  = 3'd3,
    ISSUE   = 3'd4,
    CAPTURE = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] bit_cnt;
  logic [1:0] op_sr;
  logic [3:0] a_sr;
  logic [3:0] b_sr;

  logic       in_frame;
  logic       accept;
  logic       last_bit;
  logic       cnt_clr;
  logic       sr_clr;
  logic       load_out;
  logic       capture;
  logic       err_nxt;

  // A start inside a frame always wins over the data bit presented with it.
  always_comb begin
    in_frame = (state == OP) || (state == LOAD_A) || (state == LOAD_B);
    accept   = in_frame && sin_valid && !start;
    last_bit = (state == OP) ? (bit_cnt == 3'd1) : (bit_cnt == 3'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    sr_clr    = 1'b0;
    load_out  = 1'b0;
    capture   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = OP;
          cnt_clr   = 1'b1;
          sr_clr    = 1'b1;
        end
      end
      OP, LOAD_A, LOAD_B: begin
        if (start) begin
          state_nxt = OP;
          cnt_clr   = 1'b1;
          sr_clr    = 1'b1;
          err_nxt   = 1'b1;
        end else if (accept && last_bit) begin
          cnt_clr = 1'b1;
          if (state == OP) begin
            state_nxt = LOAD_A;
          end else if (state == LOAD_A) begin
            state_nxt = LOAD_B;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      // Starts arriving while the transaction is in flight are dropped.
      ISSUE: begin
        state_nxt = CAPTURE;
        load_out  = 1'b1;
        err_nxt   = start;
      end
      CAPTURE: begin
        state_nxt = IDLE;
        capture   = 1'b1;
        err_nxt   = start;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
    end else if (cnt_clr) begin
      bit_cnt <= 3'd0;
    end else if (accept) begin
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Bits enter at the MSB so the first bit of each field settles in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_sr <= 2'd0;
      a_sr  <= 4'd0;
      b_sr  <= 4'd0;
    end else if (sr_clr) begin
      op_sr <= 2'd0;
      a_sr  <= 4'd0;
      b_sr  <= 4'd0;
    end else if (accept) begin
      case (state)
        OP:      op_sr <= {sin, op_sr[1]};
        LOAD_A:  a_sr  <= {sin, a_sr[3:1]};
        LOAD_B:  b_sr  <= {sin, b_sr[3:1]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= 4'd0;
      b_out     <= 4'd0;
      c_out     <= 2'd0;
      result    <= 4'd0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load_out) begin
        a_out <= a_sr;
        b_out <= b_sr;
        c_out <= op_sr;
      end
      if (capture) begin
        result <= e_in;
      end
      done      <= capture;
      frame_err <= err_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_operand_loader.sv
// Self-checking bench for serial_operand_loader: table vectors, corner sequences
// and randomized frames against an arithmetic reference of the ALU opcodes.
module tb_serial_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sin_valid = 1'b0;
  logic       sin = 1'b0;
  logic [3:0] e_in;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [1:0] c_out;
  logic [3:0] result;
  logic       done;
  logic       busy;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  logic [1:0] prev_c = 2'd0;
  logic [3:0] prev_a = 4'd0;
  logic [3:0] prev_b = 4'd0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         maxgap;
    logic [3:0] res;
  } vec_t;

  vec_t vecs[8];

  serial_operand_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sin_valid (sin_valid),
    .sin       (sin),
    .e_in      (e_in),
    .a_out     (a_out),
    .b_out     (b_out),
    .c_out     (c_out),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  // Downstream ALU stage as seen by the loader.
  always_comb begin
    case (c_out)
      2'd0:    e_in = a_out + b_out;
      2'd1:    e_in = {a_out[3], a_out[3], a_out[3:2]};
      2'd2:    e_in = a_out + ~b_out + 4'd1;
      default: e_in = a_out;
    endcase
  end

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [3:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int ia;
    int ib;
    int sa;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 8) ? ia - 16 : ia;
    case (op)
      2'd0:    return 4'((ia + ib) % 16);
      2'd1:    return 4'(sa >>> 2);
      2'd2:    return 4'((ia - ib + 16) % 16);
      default: return a;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_a"}, 16'(a_out), 16'd0);
    check_output({tag, "_b"}, 16'(b_out), 16'd0);
    check_output({tag, "_c"}, 16'(c_out), 16'd0);
    check_output({tag, "_result"}, 16'(result), 16'd0);
    check_output({tag, "_flags"}, 16'({done, busy, frame_err}), 16'd0);
  endtask

  // Sends a complete frame starting now; returns in the cycle after the last bit.
  task automatic apply_stimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input int maxgap);
    logic [9:0] bits;
    bit         busy_ok;
    int         gap;
    bits    = {b, a, op};
    busy_ok = 1'b1;
    start     = 1'b1;
    sin_valid = 1'b0;
    tick;
    start = 1'b0;
    if (busy !== 1'b1) busy_ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      gap = $urandom_range(maxgap, 0);
      repeat (gap) begin
        sin_valid = 1'b0;
        sin       = 1'($urandom);
        tick;
        if (busy !== 1'b1) busy_ok = 1'b0;
      end
      sin_valid = 1'b1;
      sin       = bits[i];
      tick;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    sin_valid = 1'b0;
    sin       = 1'b0;
    check_output("busy_during_frame", 16'(busy_ok), 16'd1);
  endtask

  // Called in the cycle after the last B bit; returns in the done cycle.
  task automatic wait_done(input string tag, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] res);
    int n;
    n = 0;
    check_output({tag, "_hold"}, 16'({c_out, a_out, b_out}), 16'({prev_c, prev_a, prev_b}));
    while (done !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    check_output({tag, "_latency"}, 16'(n), 16'd2);
    check_output({tag, "_c"}, 16'(c_out), 16'(op));
    check_output({tag, "_a"}, 16'(a_out), 16'(a));
    check_output({tag, "_b"}, 16'(b_out), 16'(b));
    check_output({tag, "_result"}, 16'(result), 16'(res));
    prev_c = op;
    prev_a = a;
    prev_b = b;
  endtask

  task automatic end_frame(input string tag, input int done_before);
    tick;
    check_output({tag, "_done_pulse"}, 16'(done), 16'd0);
    check_output({tag, "_done_count"}, 16'(done_cnt - done_before), 16'd1);
  endtask

  initial begin
    int         d0;
    int         e0;
    logic [1:0] rop;
    logic [3:0] ra;
    logic [3:0] rb;

    vecs[0] = '{2'd0, 4'h3, 4'h5, 0, 4'h8};
    vecs[1] = '{2'd2, 4'h2, 4'h3, 0, 4'hF};
    vecs[2] = '{2'd1, 4'h8, 4'h0, 0, 4'hE};
    vecs[3] = '{2'd0, 4'h3, 4'h5, 5, 4'h8};
    vecs[4] = '{2'd3, 4'hC, 4'h3, 2, 4'hC};
    vecs[5] = '{2'd0, 4'hF, 4'h1, 0, 4'h0};
    vecs[6] = '{2'd1, 4'h4, 4'h0, 1, 4'h1};
    vecs[7] = '{2'd2, 4'h0, 4'h1, 3, 4'hF};

    #12;
    check_reset_state("reset");
    tick;
    rst_n = 1'b1;

    // sin_valid with no start must not leave IDLE
    for (int i = 0; i < 4; i++) begin
      sin_valid = 1'b1;
      sin       = 1'($urandom);
      tick;
      check_output("idle_ignore_busy", 16'(busy), 16'd0);
    end
    sin_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].maxgap);
      wait_done($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);
      end_frame($sformatf("vec%0d", i), d0);
    end

    // restart after two A bits
    d0 = done_cnt;
    e0 = err_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin_valid = 1'b1;
      sin       = 1'($urandom);
      tick;
    end
    sin_valid = 1'b0;
    apply_stimulus(2'd3, 4'hA, 4'h6, 0);
    wait_done("restart", 2'd3, 4'hA, 4'h6, 4'hA);
    end_frame("restart", d0);
    check_output("restart_err_count", 16'(err_cnt - e0), 16'd1);

    // reset during LOAD_B
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sin_valid = 1'b1;
      sin       = 1'($urandom);
      tick;
    end
    sin_valid = 1'b0;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    tick;
    tick;
    rst_n = 1'b1;
    prev_c = 2'd0;
    prev_a = 4'd0;
    prev_b = 4'd0;
    for (int i = 0; i < 3; i++) begin
      sin_valid = 1'b1;
      sin       = 1'($urandom);
      tick;
      check_output("post_reset_idle", 16'(busy), 16'd0);
    end
    sin_valid = 1'b0;
    check_output("midreset_no_done", 16'(done_cnt - d0), 16'd0);
    d0 = done_cnt;
    apply_stimulus(2'd2, 4'h7, 4'h2, 1);
    wait_done("after_reset", 2'd2, 4'h7, 4'h2, 4'h5);
    end_frame("after_reset", d0);

    // start during CAPTURE, then back-to-back frame on the done cycle
    e0 = err_cnt;
    d0 = done_cnt;
    apply_stimulus(2'd0, 4'h6, 4'h7, 1);
    tick;
    check_output("cap_state", 16'({done, busy}), 16'b01);
    start = 1'b1;
    tick;
    start = 1'b0;
    check_output("cap_done", 16'(done), 16'd1);
    check_output("cap_frame_err", 16'(frame_err), 16'd1);
    check_output("cap_idle", 16'(busy), 16'd0);
    check_output("cap_result", 16'(result), 16'hD);
    prev_c = 2'd0;
    prev_a = 4'h6;
    prev_b = 4'h7;
    apply_stimulus(2'd1, 4'h7, 4'h0, 0);
    wait_done("b2b", 2'd1, 4'h7, 4'h0, 4'h1);
    tick;
    check_output("b2b_done_count", 16'(done_cnt - d0), 16'd2);
    check_output("b2b_err_count", 16'(err_cnt - e0), 16'd1);

    // start during ISSUE is dropped
    apply_stimulus(2'd3, 4'h5, 4'h9, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check_output("issue_frame_err", 16'(frame_err), 16'd1);
    tick;
    check_output("issue_done", 16'(done), 16'd1);
    check_output("issue_result", 16'(result), 16'h5);
    check_output("issue_idle", 16'(busy), 16'd0);
    prev_c = 2'd3;
    prev_a = 4'h5;
    prev_b = 4'h9;
    tick;

    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom);
      ra  = 4'($urandom);
      rb  = 4'($urandom);
      d0  = done_cnt;
      apply_stimulus(rop, ra, rb, 3);
      wait_done($sformatf("rand%0d", i), rop, ra, rb, alu_ref(rop, ra, rb));
      end_frame($sformatf("rand%0d", i), d0);
      repeat ($urandom_range(2, 0)) begin
        sin_valid = 1'($urandom);
        sin       = 1'($urandom);
        tick;
      end
      sin_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_operand_loader.md
SERIAL_OPERAND_LOADER -- requirements
Module: serial_operand_loader

Interface
REQ-001 The module SHALL have one clock, clk; reset is rst_n, asynchronous and active-low.
REQ-002 The module SHALL have no parameters; all widths are fixed (4-bit operands, 2-bit opcode).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  frame start strobe, sampled at each rising edge.
REQ-006 sin_valid  input  1  qualifies sin; a bit is accepted only when high.
REQ-007 sin  input  1  serial data bit, LSB first within each field.
REQ-008 e_in  input  4  combinational result returned by the downstream ALU stage.
REQ-009 a_out  output  4  registered operand A to the ALU.
REQ-010 b_out  output  4  registered operand B to the ALU.
REQ-011 c_out  output  2  registered opcode to the ALU (0 add, 1 A>>>2, 2 sub, 3 pass A).
REQ-012 result  output  4  captured ALU result.
REQ-013 done  output  1  one-cycle pulse when result updates.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 frame_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-016 The FSM SHALL have states IDLE, OP, LOAD_A, LOAD_B, ISSUE and CAPTURE.
REQ-017 Frame format: 2 opcode bits, then 4 A bits, then 4 B bits; every field LSB first.
REQ-018 Fields SHALL shift in at the MSB and move toward bit 0, so the first bit received ends in bit 0.
REQ-019 IDLE + start -> OP; the bit counter clears; sin is not sampled in the start cycle.
REQ-020 OP, LOAD_A and LOAD_B SHALL advance the counter only on cycles with sin_valid=1; gaps of any length are allowed.
REQ-021 Transitions: OP -> LOAD_A after 2 accepted bits; LOAD_A -> LOAD_B after 4; LOAD_B -> ISSUE after 4.
REQ-022 ISSUE SHALL last one cycle; at its end the shift registers load a_out, b_out and c_out together.
REQ-023 a_out, b_out and c_out SHALL hold steady at all other times, including while the next frame shifts in.
REQ-024 ISSUE -> CAPTURE; at the end of CAPTURE, result <= e_in and the FSM returns to IDLE.
REQ-025 done SHALL be high for exactly the one cycle after CAPTURE; result holds until the next CAPTURE.
REQ-026 Latency: if the last B bit is accepted in cycle N, then ISSUE=N+1, CAPTURE=N+2 and done=N+3.
REQ-027 start in OP, LOAD_A or LOAD_B SHALL pulse frame_err next cycle, discard partial fields and restart in OP with the counter cleared.
REQ-028 start in ISSUE or CAPTURE SHALL be dropped and pulse frame_err; the transaction completes normally.
REQ-029 sin_valid in IDLE, ISSUE or CAPTURE SHALL be ignored.
REQ-030 A new frame may start in the cycle done is high (FSM is in IDLE).
REQ-031 The block performs no arithmetic; e_in is captured unmodified, 4 bits, including any ALU wrap-around.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and zero the counter, shift registers, a_out, b_out, c_out, result, done, busy and frame_err.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no done pulse.
REQ-034 After rst_n deasserts, the first frame SHALL require a fresh start.

Verification
REQ-035 Op=00, A=0011, B=0101, bench ALU model -> c_out=00, a_out=0011, b_out=0101, result=1000, done exactly at N+3.
REQ-036 Op=10, A=0010, B=0011 -> result=1111 (wrap); op=01, A=1000 -> result=1110.
REQ-037 Same frame with random sin_valid gaps of 0-5 cycles -> result unchanged; busy high throughout.
REQ-038 start after 2 A bits, then full frame op=11, A=1010 -> frame_err pulse, result=1010, one done only.
REQ-039 rst_n low during LOAD_B -> all outputs 0 and busy 0 at once, no done; next frame completes correctly.
REQ-040 start during CAPTURE -> frame_err pulse, result from the current frame, FSM in IDLE; back-to-back frame starting on the done cycle is accepted.
